pwm_dimmer: RTL and testbench

//  Downstream consumer of the free-running 4-bit `counter`: compares its `count` against an

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_fade_step.sv | 40 ++++
 rtl/pwm_dimmer.sv | 107 ++++++++++
 tb/tb_pwm_dimmer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM/LED-dimmer constants: counter width, dimmer FSM encoding, duty clamp.
// Used by counter, pwm_dimmer and the LED top level.
package pwm_pkg;

    localparam int PWM_CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_RAMP = 2'd2
    } pwm_state_e;

    function automatic logic [15:0] duty_clamp(
        input logic [15:0] v,
        input logic [15:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pwm_fade_step.sv
// Wrap divider and +/-1 duty stepper for fading (built only with PWM_FADE_EN).
// tick marks every FADE_DIV-th wrap counted from the last restart.
module pwm_fade_step
    import pwm_pkg::*;
#(
    parameter int CW       = PWM_CW,
    parameter int FADE_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrap,
    input  logic        restart,
    input  logic [CW:0] active,
    input  logic [CW:0] target,
    output logic        tick,
    output logic [CW:0] stepped
);

    logic [7:0] div;

    assign tick = wrap && (div == 8'(FADE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            div <= '0;
        end else if (wrap) begin
            div <= tick ? '0 : div + 8'd1;
        end
    end

    always_comb begin
        stepped = active;
        if (target > active) begin
            stepped = active + (CW+1)'(1);
        end else if (target < active) begin
            stepped = active - (CW+1)'(1);
        end
    end

endmodule

// File: rtl/pwm_dimmer.sv
// PWM compare stage with double-buffered duty committed at period wrap.
// Define PWM_FADE_EN to fade the active duty toward new targets in +/-1 steps.
module pwm_dimmer
    import pwm_pkg::*;
#(
    parameter int CW = PWM_CW
`ifdef PWM_FADE_EN
    ,
    parameter int FADE_DIV = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count,
    input  logic [CW:0]   duty_in,
    input  logic          duty_wr,
    output logic          duty_busy,
    output logic [CW:0]   duty_active,
    output logic          period_start,
    output logic          pwm_out
);

    pwm_state_e  state, state_nxt;
    logic [CW:0] pending;
    logic [CW:0] duty_cap;
    logic [CW:0] duty_next;
    logic        wrap;

    assign wrap      = (count == '0);
    assign duty_busy = (state != S_IDLE);
    assign duty_cap  = (CW+1)'(duty_clamp(16'(duty_in), 16'(1 << CW)));

`ifdef PWM_FADE_EN
    logic        tick;
    logic        restart;
    logic [CW:0] stepped;

    pwm_fade_step #(
        .CW      (CW),
        .FADE_DIV(FADE_DIV)
    ) u_fade (
        .clk    (clk),
        .rst    (rst),
        .wrap   (wrap),
        .restart(restart),
        .active (duty_active),
        .target (pending),
        .tick   (tick),
        .stepped(stepped)
    );

    always_comb begin
        state_nxt = state;
        duty_next = duty_active;
        restart   = 1'b0;
        case (state)
            S_IDLE: if (duty_wr) state_nxt = S_PEND;
            S_PEND: begin
                if (!duty_wr && wrap) begin
                    restart   = 1'b1;
                    duty_next = stepped;
                    state_nxt = (stepped == pending) ? S_IDLE : S_RAMP;
                end
            end
            S_RAMP: begin
                if (tick && duty_active != pending) duty_next = stepped;
                // a write here retargets; stay ramping until it is seen
                if (!duty_wr && duty_next == pending) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
`else
    always_comb begin
        state_nxt = state;
        duty_next = duty_active;
        case (state)
            S_IDLE: if (duty_wr) state_nxt = S_PEND;
            S_PEND: begin
                // a write on the wrap cycle defers the commit one period
                if (!duty_wr && wrap) begin
                    duty_next = pending;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pending      <= '0;
            duty_active  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            duty_active  <= duty_next;
            pwm_out      <= ({1'b0, count} < duty_next);
            period_start <= wrap;
            if (duty_wr) pending <= duty_cap;
        end
    end

endmodule

// File: tb/tb_pwm_dimmer.sv
// Directed bench for pwm_dimmer driven by a free-running 4-bit counter.
// Fade steps run only when PWM_FADE_EN is defined (FADE_DIV=2).
module tb_pwm_dimmer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count = 4'd0;
    logic [4:0] duty_in;
    logic       duty_wr;
    logic       duty_busy;
    logic [4:0] duty_active;
    logic       period_start;
    logic       pwm_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // stand-in for the free-running counter; not affected by rst
    always @(posedge clk) count <= count + 4'd1;

    pwm_dimmer #(
        .CW(4)
`ifdef PWM_FADE_EN
        ,
        .FADE_DIV(2)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .duty_in     (duty_in),
        .duty_wr     (duty_wr),
        .duty_busy   (duty_busy),
        .duty_active (duty_active),
        .period_start(period_start),
        .pwm_out     (pwm_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input logic [3:0] c);
        int n = 0;
        while (count !== c && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (count !== c) chk("goto_timeout", 32'(count), 32'(c));
    endtask

    task automatic wr(input logic [4:0] v, input logic [3:0] at);
        goto(at);
        duty_in = v;
        duty_wr = 1'b1;
        @(negedge clk);
        duty_wr = 1'b0;
    endtask

    task automatic run_period(input logic do_wr, input logic [4:0] v,
                              output int highs, output int starts,
                              output logic first);
        goto(4'd0);
        highs  = 0;
        starts = 0;
        first  = 1'b0;
        if (do_wr) begin
            duty_in = v;
            duty_wr = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            duty_wr = 1'b0;
            highs  += int'(pwm_out);
            starts += int'(period_start);
            if (i == 0) first = pwm_out | (period_start << 1);
        end
    endtask

    int   h, s;
    logic f;
`ifdef PWM_FADE_EN
    int   exp_a1 [6] = '{1, 1, 2, 2, 3, 3};
    int   exp_b1 [6] = '{1, 1, 1, 1, 0, 0};
`endif

    initial begin
        rst     = 1'b1;
        duty_wr = 1'b0;
        duty_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_active", 32'(duty_active), 0);
        chk("rst_busy", 32'(duty_busy), 0);
        chk("rst_pstart", 32'(period_start), 0);
        rst = 1'b0;

        run_period(1'b0, 5'd0, h, s, f);
        chk("idle_highs", 32'(h), 0);
        chk("idle_starts", 32'(s), 1);

        wr(5'd4, 4'd5);
        chk("d4_busy_pend", 32'(duty_busy), 1);
        chk("d4_active_old", 32'(duty_active), 0);
        goto(4'd0);
        chk("d4_busy_atwrap", 32'(duty_busy), 1);
        run_period(1'b0, 5'd0, h, s, f);
        chk("d4_highs", 32'(h), 4);
        chk("d4_starts", 32'(s), 1);
        chk("d4_first_aligned", 32'(f), 1);
        chk("d4_busy_done", 32'(duty_busy), 0);
        chk("d4_active", 32'(duty_active), 4);

        wr(5'd0, 4'd3);
        run_period(1'b0, 5'd0, h, s, f);
        chk("d0_highs", 32'(h), 0);
        wr(5'd16, 4'd3);
        run_period(1'b0, 5'd0, h, s, f);
        chk("d16_highs", 32'(h), 16);
        chk("d16_active", 32'(duty_active), 16);
        wr(5'd20, 4'd3);
        chk("d20_busy", 32'(duty_busy), 1);
        run_period(1'b0, 5'd0, h, s, f);
        chk("d20_highs", 32'(h), 16);
        chk("d20_clamped", 32'(duty_active), 16);
        chk("d20_busy_clr", 32'(duty_busy), 0);

        run_period(1'b1, 5'd9, h, s, f);
        chk("wrapwr_old_highs", 32'(h), 16);
        chk("wrapwr_busy", 32'(duty_busy), 1);
        chk("wrapwr_active_old", 32'(duty_active), 16);
        run_period(1'b0, 5'd0, h, s, f);
        chk("wrapwr_new_highs", 32'(h), 9);
        chk("wrapwr_active", 32'(duty_active), 9);

        wr(5'd3, 4'd2);
        wr(5'd11, 4'd6);
        run_period(1'b0, 5'd0, h, s, f);
        chk("lastwr_highs", 32'(h), 11);
        chk("lastwr_active", 32'(duty_active), 11);

        wr(5'd13, 4'd2);
        goto(4'd7);
        chk("prerst_pwm", 32'(pwm_out), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_pwm", 32'(pwm_out), 0);
        chk("midrst_active", 32'(duty_active), 0);
        chk("midrst_busy", 32'(duty_busy), 0);
        for (int k = 0; k < 2; k++) begin
            run_period(1'b0, 5'd0, h, s, f);
            chk("postrst_highs", 32'(h), 0);
            chk("postrst_active", 32'(duty_active), 0);
        end

`ifdef PWM_FADE_EN
        wr(5'd3, 4'd4);
        for (int k = 0; k < 6; k++) begin
            run_period(1'b0, 5'd0, h, s, f);
            chk("fade_up_active", 32'(duty_active), 32'(exp_a1[k]));
            chk("fade_up_busy", 32'(duty_busy), 32'(exp_b1[k]));
            chk("fade_up_highs", 32'(h), 32'(exp_a1[k]));
        end
        wr(5'd0, 4'd4);
        run_period(1'b0, 5'd0, h, s, f);
        chk("fade_dn_active", 32'(duty_active), 2);
        chk("fade_dn_busy", 32'(duty_busy), 1);
        wr(5'd1, 4'd4);
        run_period(1'b0, 5'd0, h, s, f);
        chk("retgt_hold", 32'(duty_active), 2);
        chk("retgt_busy", 32'(duty_busy), 1);
        run_period(1'b0, 5'd0, h, s, f);
        chk("retgt_active", 32'(duty_active), 1);
        chk("retgt_busy_clr", 32'(duty_busy), 0);
        chk("retgt_highs", 32'(h), 1);
        run_period(1'b0, 5'd0, h, s, f);
        chk("retgt_stable", 32'(duty_active), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
